// File: rtl/traffic_conflict_monitor.sv
// Independent checker on the four-way lamp bus: latches the first safety violation
// (code + lane) and requests an all-red flash override until a clean clear.
module traffic_conflict_monitor #(
  parameter int MIN_GREEN  = 6,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_STALL  = 16,
  parameter int BLANK      = 2,
  parameter int FLASH_DIV  = 4,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] l1,
  input  logic [2:0] l2,
  input  logic [2:0] l3,
  input  logic [2:0] l4,
  input  logic       clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_lane,
  output logic       force_flash,
  output logic       flash_red
);

  localparam logic [2:0]    LAMP_G      = 3'b100;
  localparam logic [2:0]    LAMP_Y      = 3'b010;
  localparam logic [2:0]    LAMP_R      = 3'b001;
  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] MIN_G_C     = CW'(MIN_GREEN);
  localparam logic [CW-1:0] MIN_Y_C     = CW'(MIN_YELLOW);
  localparam logic [CW-1:0] MAX_STALL_C = CW'(MAX_STALL);
  localparam logic [CW-1:0] BLANK_C     = CW'(BLANK);
  localparam logic [CW-1:0] FLASH_END_C = CW'(FLASH_DIV - 1);

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_ILLEGAL  = 3'd1,
    FC_CONFLICT = 3'd2,
    FC_SEQ      = 3'd3,
    FC_DWELL    = 3'd4,
    FC_ORDER    = 3'd5,
    FC_STALL    = 3'd6
  } faultCode_e;

  logic [2:0]    w_lamp [4];
  logic [2:0]    r_prev [4];
  logic [CW-1:0] r_dwell [4];
  logic [3:0]    r_seen;
  logic [CW-1:0] r_stall;
  logic [CW-1:0] r_blank;
  logic          r_expValid;
  logic [1:0]    r_expLane;
  logic          r_fault;
  faultCode_e    r_code;
  logic [1:0]    r_lane;
  logic [CW-1:0] r_flashCnt;
  logic          r_flash;

  logic [3:0]    w_changed, w_isG, w_isY, w_illegal, w_conflict;
  logic [3:0]    w_seq, w_dwell, w_entry, w_order;
  logic          w_anyChange, w_blanking, w_clrAccept, w_stallHit, w_violation;
  logic [CW-1:0] w_stallNext;
  logic [1:0]    w_entryLane, w_lane;
  faultCode_e    w_code;

  assign w_lamp[0] = l1;
  assign w_lamp[1] = l2;
  assign w_lamp[2] = l3;
  assign w_lamp[3] = l4;

  function automatic logic [1:0] lowestLane(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic multiHot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Per-lane violation vectors, then one priority pick of class and lowest lane.
  always_comb begin
    w_changed = '0;
    w_isG     = '0;
    w_isY     = '0;
    w_illegal = '0;
    w_seq     = '0;
    w_dwell   = '0;
    w_entry   = '0;
    for (int i = 0; i < 4; i++) begin
      w_changed[i] = w_lamp[i] != r_prev[i];
      w_isG[i]     = w_lamp[i] == LAMP_G;
      w_isY[i]     = w_lamp[i] == LAMP_Y;
      w_illegal[i] = !(w_isG[i] || w_isY[i] || (w_lamp[i] == LAMP_R));
      w_seq[i]     = w_changed[i] &&
                     !(((r_prev[i] == LAMP_R) && w_isY[i]) ||
                       ((r_prev[i] == LAMP_Y) && w_isG[i]) ||
                       ((r_prev[i] == LAMP_G) && (w_lamp[i] == LAMP_R)));
      w_dwell[i]   = r_seen[i] &&
                     (((r_prev[i] == LAMP_G) && (w_lamp[i] == LAMP_R) && (r_dwell[i] < MIN_G_C)) ||
                      ((r_prev[i] == LAMP_Y) && w_isG[i] && (r_dwell[i] < MIN_Y_C)));
      w_entry[i]   = w_changed[i] && w_isG[i] &&
                     ((r_prev[i] == LAMP_R) || (r_prev[i] == LAMP_Y));
    end
    w_conflict  = (multiHot(w_isG) ? w_isG : 4'd0) | (multiHot(w_isY) ? w_isY : 4'd0);
    w_entryLane = lowestLane(w_entry);
    w_order     = r_expValid ? (w_entry & ~(4'b0001 << r_expLane)) : 4'd0;
    w_anyChange = |w_changed;
    w_stallNext = w_anyChange ? '0 : satInc(r_stall);
    w_stallHit  = w_stallNext >= MAX_STALL_C;
    w_blanking  = r_blank != '0;
    w_clrAccept = clr && r_fault && (l1 == LAMP_R) && (l2 == LAMP_R) &&
                  (l3 == LAMP_R) && (l4 == LAMP_R);

    w_code = FC_NONE;
    w_lane = 2'd0;
    if (|w_illegal) begin
      w_code = FC_ILLEGAL;
      w_lane = lowestLane(w_illegal);
    end else if (|w_conflict) begin
      w_code = FC_CONFLICT;
      w_lane = lowestLane(w_conflict);
    end else if (|w_seq) begin
      w_code = FC_SEQ;
      w_lane = lowestLane(w_seq);
    end else if (|w_dwell) begin
      w_code = FC_DWELL;
      w_lane = lowestLane(w_dwell);
    end else if (|w_order) begin
      w_code = FC_ORDER;
      w_lane = lowestLane(w_order);
    end else if (w_stallHit) begin
      w_code = FC_STALL;
    end
    w_violation = w_code != FC_NONE;
  end

  // History and counters keep tracking through blanking; only fault raising is gated.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_prev[i]  <= LAMP_R;
        r_dwell[i] <= '0;
      end
      r_seen     <= '0;
      r_stall    <= '0;
      r_blank    <= BLANK_C;
      r_expValid <= 1'b0;
      r_expLane  <= 2'd0;
      r_fault    <= 1'b0;
      r_code     <= FC_NONE;
      r_lane     <= 2'd0;
      r_flashCnt <= '0;
      r_flash    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_prev[i]  <= w_lamp[i];
        r_dwell[i] <= w_changed[i] ? CNT_ONE : satInc(r_dwell[i]);
        r_seen[i]  <= (w_blanking || w_clrAccept) ? 1'b0 : (r_seen[i] || w_changed[i]);
      end
      r_stall <= w_clrAccept ? '0 : w_stallNext;
      r_blank <= w_clrAccept ? BLANK_C : (w_blanking ? r_blank - CNT_ONE : '0);

      if (w_blanking || w_clrAccept) begin
        r_expValid <= 1'b0;
      end else if (|w_entry) begin
        r_expValid <= 1'b1;
        r_expLane  <= w_entryLane + 2'd1;
      end

      if (w_clrAccept) begin
        r_fault <= 1'b0;
        r_code  <= FC_NONE;
        r_lane  <= 2'd0;
      end else if (!r_fault && !w_blanking && w_violation) begin
        r_fault <= 1'b1;
        r_code  <= w_code;
        r_lane  <= w_lane;
      end

      if (!r_fault || w_clrAccept) begin
        r_flashCnt <= '0;
        r_flash    <= 1'b0;
      end else if (r_flashCnt == FLASH_END_C) begin
        r_flashCnt <= '0;
        r_flash    <= !r_flash;
      end else begin
        r_flashCnt <= r_flashCnt + CNT_ONE;
      end
    end
  end

  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign fault_lane  = r_lane;
  assign force_flash = r_fault;
  assign flash_red   = r_flash;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboarded directed bench: each driven cycle queues its hand-derived outputs,
// and an independent monitor compares them just after the following clock edge.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] X = 3'b000;

  typedef struct {
    logic       chk;
    logic       fault;
    logic [2:0] code;
    logic [1:0] lane;
    logic       flash;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] l1 = R, l2 = R, l3 = R, l4 = R;
  logic       clr = 1'b0;
  logic       fault, force_flash, flash_red;
  logic [2:0] fault_code;
  logic [1:0] fault_lane;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  traffic_conflict_monitor dut (
    .clk(clk), .reset(reset), .l1(l1), .l2(l2), .l3(l3), .l4(l4), .clr(clr),
    .fault(fault), .fault_code(fault_code), .fault_lane(fault_lane),
    .force_flash(force_flash), .flash_red(flash_red)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input string nm, input logic rstIn,
                               input logic [2:0] a, b, c, d, input logic clrIn,
                               input logic eF, input logic [2:0] eC,
                               input logic [1:0] eL, input logic eFl);
    exp_t e;
    @(negedge clk);
    reset = rstIn;
    l1 = a; l2 = b; l3 = c; l4 = d;
    clr = clrIn;
    e.chk = 1'b1; e.fault = eF; e.code = eC; e.lane = eL; e.flash = eFl;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic stepOk(input string nm, input logic [2:0] a, b, c, d);
    applyStimulus(nm, 1'b0, a, b, c, d, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
  endtask

  task automatic stepFault(input string nm, input logic [2:0] a, b, c, d,
                           input logic [2:0] eC, input logic [1:0] eL);
    applyStimulus(nm, 1'b0, a, b, c, d, 1'b0, 1'b1, eC, eL, 1'b0);
  endtask

  task automatic resetDut(input string nm);
    applyStimulus(nm, 1'b1, R, R, R, R, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    checks++;
    if (fault !== e.fault || fault_code !== e.code || fault_lane !== e.lane ||
        force_flash !== e.fault || flash_red !== e.flash) begin
      errors++;
      $display("[TB] FAIL %s: got fault=%0b code=%0d lane=%0d force=%0b flash=%0b, expected fault=%0b code=%0d lane=%0d force=%0b flash=%0b",
               nm, fault, fault_code, fault_lane, force_flash, flash_red,
               e.fault, e.code, e.lane, e.fault, e.flash);
    end
  endtask

  // Monitor: one queued expectation per clock edge, checked 1 time unit after it.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        if (e.chk) checkOutput(e, nm);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [2:0] ln [4];
    int g;

    resetDut("reset state");
    resetDut("reset state");

    // Three legal rounds; each lane: Y for 3 cycles overlapping the previous green, then G for 8.
    for (int t = 0; t < 99; t++) begin
      for (int k = 0; k < 4; k++) ln[k] = R;
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 4; k++) begin
          g = 3 + 8 * (4 * r + k);
          if (t >= g - 3 && t < g) ln[k] = Y;
          if (t >= g && t < g + 8) ln[k] = G;
        end
      end
      stepOk("legal rotation", ln[0], ln[1], ln[2], ln[3]);
    end
    stepOk("rotation end", R, R, R, R);

    for (int j = 1; j <= 15; j++)
      applyStimulus("stall pending, clr without fault", 1'b0, R, R, R, R, j <= 3,
                    1'b0, 3'd0, 2'd0, 1'b0);
    stepFault("stall", R, R, R, R, 3'd6, 2'd0);
    for (int j = 1; j <= 13; j++)
      applyStimulus("flash cadence", 1'b0, R, R, R, R, 1'b0, 1'b1, 3'd6, 2'd0, ((j / 4) % 2) == 1);

    applyStimulus("clr refused, lane2 green", 1'b0, R, G, R, R, 1'b1, 1'b1, 3'd6, 2'd0, 1'b1);
    applyStimulus("clr accepted", 1'b0, R, R, R, R, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0);
    stepOk("blank after clear", G, R, G, R);
    stepOk("blank after clear", G, R, G, R);
    stepFault("conflict after clear", G, R, G, R, 3'd2, 2'd0);
    resetDut("reset mid-fault");

    stepOk("blank", R, R, R, R);
    stepOk("blank", R, R, R, R);
    stepFault("illegal lane2", R, X, R, R, 3'd1, 2'd1);
    stepFault("illegal latched", G, R, G, R, 3'd1, 2'd1);
    resetDut("reset");

    stepOk("blank", R, R, R, R);
    stepOk("blank", R, R, R, R);
    stepOk("seq setup", R, Y, R, R);
    stepOk("seq setup", R, Y, R, R);
    stepOk("seq setup", R, G, R, R);
    stepFault("seq G to Y", R, Y, R, R, 3'd3, 2'd1);
    resetDut("reset");

    stepOk("blank", R, R, R, R);
    stepOk("blank", R, R, R, R);
    stepOk("dwell setup", R, R, R, Y);
    stepOk("dwell setup min yellow", R, R, R, Y);
    stepOk("dwell setup", R, R, R, G);
    stepOk("dwell setup", R, R, R, G);
    stepOk("dwell setup", R, R, R, G);
    stepFault("short green", R, R, R, R, 3'd4, 2'd3);
    resetDut("reset");

    stepOk("blank", R, R, R, R);
    stepOk("blank", R, R, R, R);
    stepOk("order setup", Y, R, R, R);
    stepOk("order setup", Y, R, R, R);
    for (int j = 0; j < 6; j++) stepOk("order setup min green", G, R, R, R);
    stepOk("green exactly min", R, R, R, R);
    stepOk("order setup", R, R, Y, R);
    stepOk("order setup", R, R, Y, R);
    stepFault("order skip", R, R, G, R, 3'd5, 2'd2);
    resetDut("reset");

    stepOk("blank", R, R, R, R);
    stepOk("blank", R, R, R, R);
    stepOk("conflict setup", Y, R, R, R);
    stepOk("conflict setup", Y, R, R, R);
    stepOk("conflict setup", G, R, R, R);
    stepFault("conflict two greens", G, R, G, R, 3'd2, 2'd0);
    resetDut("reset");

    stepOk("blank", R, R, R, R);
    stepOk("blank", R, R, R, R);
    stepOk("short yellow setup", Y, R, R, R);
    stepFault("short yellow", G, R, R, R, 3'd4, 2'd0);

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
